// File: rtl/cavlc_mb_scheduler_if.sv
// Decoder-side handshake between the macroblock scheduler and the
// CAVLC 4x4-block decoder.
interface cavlc_mb_scheduler_if #(
    parameter int TCW = 5
);
    logic           CavlcEnable;
    logic [4:0]     nC;
    logic [3:0]     BlkIdx;
    logic           BlockDone;
    logic [TCW-1:0] TotalCoeffOut;

    modport master (
        output CavlcEnable, nC, BlkIdx,
        input  BlockDone, TotalCoeffOut
    );

    modport slave (
        input  CavlcEnable, nC, BlkIdx,
        output BlockDone, TotalCoeffOut
    );
endinterface

// File: rtl/cavlc_mb_scheduler.sv
// Macroblock sequencer for the CAVLC block decoder: walks 16 luma blocks,
// derives nC from neighbour TotalCoeff values and records each result.
module cavlc_mb_scheduler #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int TCW = 5
) (
    input  logic                 Clk,
    input  logic                 nReset,
    input  logic                 MbStart,
    input  logic [3:0]           Cbp,
    input  logic                 LeftAvail,
    input  logic                 TopAvail,
    input  logic [4*TCW-1:0]     LeftTc,
    input  logic [4*TCW-1:0]     TopTc,
    cavlc_mb_scheduler_if.master dec,
    output logic                 MbBusy,
    output logic                 MbDone,
    output logic                 MbError,
    output logic [16*TCW-1:0]    MbTc
);
    localparam int CW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {IDLE, SETUP, RUN, NEXT, DONE} state_t;

    state_t         state, stateNext;
    logic [3:0]     cbpQ;
    logic           leftAvailQ, topAvailQ;
    logic [4*TCW-1:0] leftTcQ, topTcQ;
    logic [3:0]     blkIdx;
    logic [4:0]     nCQ;
    logic [CW-1:0]  tmoCnt;
    logic           errQ;
    logic [TCW-1:0] tcTab [16];

    logic           coded, timeout;
    logic [1:0]     bx, by;
    logic [TCW-1:0] nA, nB;
    logic           aOk, bOk;
    logic [TCW:0]   sum;
    logic [4:0]     nCNew;

    function automatic logic [3:0] blkOf(logic [1:0] x, logic [1:0] y);
        return {y[1], x[1], y[0], x[0]};
    endfunction

    assign coded   = cbpQ[blkIdx[3:2]];
    assign timeout = (tmoCnt == CW'(TIMEOUT_CYCLES - 1));
    assign bx      = {blkIdx[2], blkIdx[0]};
    assign by      = {blkIdx[3], blkIdx[1]};

    // Inner neighbours come from this MB's table, edge ones from the latched context
    always_comb begin
        nA    = '0;
        nB    = '0;
        aOk   = 1'b0;
        bOk   = 1'b0;
        sum   = '0;
        nCNew = '0;
        if (bx != 2'd0) begin
            nA  = tcTab[blkOf(bx - 2'd1, by)];
            aOk = 1'b1;
        end else begin
            nA  = leftTcQ[TCW*by +: TCW];
            aOk = leftAvailQ;
        end
        if (by != 2'd0) begin
            nB  = tcTab[blkOf(bx, by - 2'd1)];
            bOk = 1'b1;
        end else begin
            nB  = topTcQ[TCW*bx +: TCW];
            bOk = topAvailQ;
        end
        sum = {1'b0, nA} + {1'b0, nB} + (TCW+1)'(1);
        unique case ({aOk, bOk})
            2'b11:   nCNew = 5'(sum[TCW:1]);
            2'b10:   nCNew = 5'(nA);
            2'b01:   nCNew = 5'(nB);
            default: nCNew = '0;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!nReset) state <= IDLE;
        else         state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE:    if (MbStart) stateNext = SETUP;
            SETUP:   stateNext = coded ? RUN : NEXT;
            RUN: begin
                if (dec.BlockDone)  stateNext = NEXT;
                else if (timeout)   stateNext = IDLE;
            end
            NEXT:    stateNext = (blkIdx == 4'd15) ? DONE : SETUP;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!nReset) begin
            cbpQ       <= '0;
            leftAvailQ <= 1'b0;
            topAvailQ  <= 1'b0;
            leftTcQ    <= '0;
            topTcQ     <= '0;
            blkIdx     <= '0;
            nCQ        <= '0;
            tmoCnt     <= '0;
            errQ       <= 1'b0;
            for (int i = 0; i < 16; i++) tcTab[i] <= '0;
        end else begin
            errQ <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (MbStart) begin
                        cbpQ       <= Cbp;
                        leftAvailQ <= LeftAvail;
                        topAvailQ  <= TopAvail;
                        leftTcQ    <= LeftTc;
                        topTcQ     <= TopTc;
                        blkIdx     <= '0;
                        for (int i = 0; i < 16; i++) tcTab[i] <= '0;
                    end
                end
                SETUP: begin
                    nCQ <= nCNew;
                    if (!coded) tcTab[blkIdx] <= '0;
                end
                RUN: begin
                    if (dec.BlockDone) begin
                        tcTab[blkIdx] <= dec.TotalCoeffOut;
                    end else if (timeout) begin
                        errQ   <= 1'b1;
                        blkIdx <= '0;
                        tmoCnt <= '0;
                    end else begin
                        tmoCnt <= tmoCnt + 1'b1;
                    end
                end
                NEXT: begin
                    tmoCnt <= '0;
                    if (blkIdx != 4'd15) blkIdx <= blkIdx + 4'd1;
                end
                DONE:    blkIdx <= '0;
                default: blkIdx <= '0;
            endcase
        end
    end

    assign dec.CavlcEnable = (state == RUN);
    assign dec.nC          = nCQ;
    assign dec.BlkIdx      = blkIdx;
    assign MbBusy          = (state != IDLE);
    assign MbDone          = (state == DONE);
    assign MbError         = errQ;

    always_comb begin
        MbTc = '0;
        for (int k = 0; k < 16; k++) MbTc[TCW*k +: TCW] = tcTab[k];
    end
endmodule

// File: tb/tb_cavlc_mb_scheduler.sv
// Directed bench for the CAVLC macroblock scheduler with a small
// behavioural decoder answering each enabled block.
module tb_cavlc_mb_scheduler;
    localparam int TCW = 5;
    localparam int TMO = 20;

    logic        Clk = 1'b0;
    logic        nReset = 1'b0;
    logic        MbStart = 1'b0;
    logic [3:0]  Cbp = '0;
    logic        LeftAvail = 1'b0;
    logic        TopAvail = 1'b0;
    logic [19:0] LeftTc = '0;
    logic [19:0] TopTc = '0;
    logic        MbBusy, MbDone, MbError;
    logic [79:0] MbTc;

    cavlc_mb_scheduler_if #(.TCW(TCW)) dif ();

    cavlc_mb_scheduler #(.TIMEOUT_CYCLES(TMO), .TCW(TCW)) dut (
        .Clk       (Clk),
        .nReset    (nReset),
        .MbStart   (MbStart),
        .Cbp       (Cbp),
        .LeftAvail (LeftAvail),
        .TopAvail  (TopAvail),
        .LeftTc    (LeftTc),
        .TopTc     (TopTc),
        .dec       (dif),
        .MbBusy    (MbBusy),
        .MbDone    (MbDone),
        .MbError   (MbError),
        .MbTc      (MbTc)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int failures = 0;

    task automatic check(string tag, logic [79:0] got, logic [79:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Decoder model: answers TotalCoeff=k+1 on the 3rd enabled cycle
    int         decMode = 0;
    bit         stray = 1'b0;
    int         runCnt = 0;
    int         enCount = 0;
    int         doneCount = 0;
    int         errCount = 0;
    logic [4:0] nCLog [16];

    initial begin
        dif.BlockDone = 1'b0;
        dif.TotalCoeffOut = '0;
        forever begin
            @(negedge Clk);
            if (dif.CavlcEnable) begin
                enCount++;
                runCnt++;
                if (runCnt == 1) nCLog[dif.BlkIdx] = dif.nC;
                if (decMode == 0 && runCnt == 3) begin
                    dif.BlockDone = 1'b1;
                    dif.TotalCoeffOut = 5'(dif.BlkIdx + 1);
                end else begin
                    dif.BlockDone = 1'b0;
                    dif.TotalCoeffOut = '0;
                end
            end else begin
                runCnt = 0;
                dif.BlockDone = stray && MbBusy;
                dif.TotalCoeffOut = stray ? 5'd31 : 5'd0;
            end
            if (MbDone) doneCount++;
            if (MbError) errCount++;
        end
    end

    function automatic logic [79:0] seqTc(int n);
        logic [79:0] v = '0;
        for (int k = 0; k < n; k++) v[5*k +: 5] = 5'(k + 1);
        return v;
    endfunction

    task automatic runMb(input bit midPulse, output int cyc);
        @(negedge Clk);
        MbStart = 1'b1;
        @(negedge Clk);
        MbStart = 1'b0;
        cyc = 1;
        while (!MbDone && !MbError && cyc < 3000) begin
            @(negedge Clk);
            cyc++;
            if (midPulse && cyc == 20) begin
                MbStart = 1'b1;
                Cbp = 4'h0;
                LeftAvail = 1'b1;
                TopAvail = 1'b1;
                LeftTc = '1;
                TopTc = '1;
            end else begin
                MbStart = 1'b0;
            end
        end
        MbStart = 1'b0;
    endtask

    int cyc, e0, d0, r0, n;
    int blkList [9] = '{0, 1, 2, 3, 4, 5, 6, 8, 15};
    int nCExp   [9] = '{0, 1, 1, 3, 2, 5, 5, 3, 15};

    initial begin
        repeat (3) @(negedge Clk);
        check("rst_en", dif.CavlcEnable, 0);
        check("rst_nc", dif.nC, 0);
        check("rst_blk", dif.BlkIdx, 0);
        check("rst_flags", {MbBusy, MbDone, MbError}, 0);
        check("rst_tc", MbTc, 0);
        nReset = 1'b1;

        // All blocks skipped
        e0 = enCount; d0 = doneCount; r0 = errCount;
        runMb(1'b0, cyc);
        check("skip_lat", cyc, 33);
        repeat (2) @(negedge Clk);
        check("skip_en", enCount - e0, 0);
        check("skip_done", doneCount - d0, 1);
        check("skip_err", errCount - r0, 0);
        check("skip_tc", MbTc, 0);

        // All blocks coded, no neighbours
        Cbp = 4'hF;
        e0 = enCount; d0 = doneCount; r0 = errCount;
        runMb(1'b0, cyc);
        check("full_lat", cyc, 81);
        repeat (2) @(negedge Clk);
        check("full_tc", MbTc, seqTc(16));
        check("full_done", doneCount - d0, 1);
        check("full_err", errCount - r0, 0);
        check("full_en", enCount - e0, 48);
        for (int i = 0; i < 9; i++)
            check($sformatf("full_nc%0d", blkList[i]),
                  nCLog[blkList[i]], nCExp[i]);

        // Neighbours available, only the first 8x8 coded
        Cbp = 4'h1;
        LeftAvail = 1'b1;
        TopAvail = 1'b1;
        LeftTc = {5'd0, 5'd0, 5'd3, 5'd7};
        TopTc = {5'd0, 5'd0, 5'd9, 5'd4};
        e0 = enCount;
        runMb(1'b0, cyc);
        check("nb_lat", cyc, 45);
        repeat (2) @(negedge Clk);
        check("nb_tc", MbTc, seqTc(4));
        check("nb_en", enCount - e0, 12);
        check("nb_nc0", nCLog[0], 6);
        check("nb_nc1", nCLog[1], 5);
        check("nb_nc2", nCLog[2], 2);
        check("nb_nc3", nCLog[3], 3);

        // Decoder never answers
        Cbp = 4'hF;
        LeftAvail = 1'b0;
        TopAvail = 1'b0;
        LeftTc = '0;
        TopTc = '0;
        decMode = 1;
        e0 = enCount; d0 = doneCount; r0 = errCount;
        runMb(1'b0, cyc);
        check("tmo_lat", cyc, TMO + 2);
        check("tmo_state", {dif.CavlcEnable, MbBusy, MbDone}, 0);
        @(negedge Clk);
        check("tmo_pulse", MbError, 0);
        repeat (2) @(negedge Clk);
        check("tmo_en", enCount - e0, TMO);
        check("tmo_err", errCount - r0, 1);
        check("tmo_done", doneCount - d0, 0);
        check("tmo_tc", MbTc, 0);
        decMode = 0;

        // Stray BlockDone outside RUN and a second MbStart mid-MB
        stray = 1'b1;
        d0 = doneCount;
        runMb(1'b1, cyc);
        check("ign_lat", cyc, 81);
        repeat (2) @(negedge Clk);
        stray = 1'b0;
        check("ign_tc", MbTc, seqTc(16));
        check("ign_done", doneCount - d0, 1);
        check("ign_nc3", nCLog[3], 3);
        check("ign_nc15", nCLog[15], 15);

        // Reset in the middle of block 5
        Cbp = 4'hF;
        LeftAvail = 1'b0;
        TopAvail = 1'b0;
        LeftTc = '0;
        TopTc = '0;
        @(negedge Clk);
        MbStart = 1'b1;
        @(negedge Clk);
        MbStart = 1'b0;
        n = 0;
        while (!(dif.CavlcEnable && dif.BlkIdx == 4'd5) && n < 500) begin
            @(negedge Clk);
            n++;
        end
        check("rst_reach", n < 500, 1);
        nReset = 1'b0;
        @(negedge Clk);
        nReset = 1'b1;
        check("mrst_out", {dif.CavlcEnable, dif.nC, dif.BlkIdx,
                           MbBusy, MbDone, MbError}, 0);
        check("mrst_tc", MbTc, 0);
        d0 = doneCount;
        runMb(1'b0, cyc);
        check("post_lat", cyc, 81);
        repeat (2) @(negedge Clk);
        check("post_tc", MbTc, seqTc(16));
        check("post_done", doneCount - d0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
